id_tracker_table: RTL and testbench
===================================

// Module: id_tracker_table
// PURPOSE
//  Per-ID outstanding-transaction table for the AXI monitor. Allocates one entry per distinct
//  in-flight ID on request acceptance, counts outstanding beats/txns per entry, and frees the
//  entry when its last response retires. Each entry state {id, free, cnt} is the head_tail
//  record evaluated by the downstream per-entry ID match comparators.
// PARAMETERS
//  NumEntries    4   number of table entries (distinct IDs tracked concurrently), >=1
//  IdWidth       4   width of AXI ID
//  MaxTxnsPerId  8   max outstanding transactions per entry; CntWidth = $clog2(MaxTxnsPerId+1)
//  TimeoutCycles 16  idle cycles before timeout flag (used only with ID_TRACKER_TIMEOUT_EN)
// PORTS
//  clk_i         in   1                      clock
//  rst_ni        in   1                      async active-low reset
//  req_valid_i   in   1                      new transaction with req_id_i
//  req_id_i      in   IdWidth                ID of new transaction
//  req_ready_o   out  1                      table can accept req_id_i this cycle
//  rsp_valid_i   in   1                      transaction retirement (last response beat)
//  rsp_id_i      in   IdWidth                ID being retired
//  rsp_err_o     out  1                      registered: prior rsp ID had no live entry
//  full_o        out  1                      all entries occupied
//  empty_o       out  1                      all entries free
//  timeout_o     out  1                      registered one-cycle pulse: an entry timed out
//  timeout_id_o  out  IdWidth                ID of timed-out entry (valid with timeout_o)
// BEHAVIOUR
//  - Reset: all entries free=1, cnt=0, id=0; req_ready_o=1, rsp_err_o=0, full_o=0,
//    empty_o=1, timeout_o=0, timeout_id_o=0. Reset mid-operation drops all state immediately.
//  - Match: entry i matches X iff !free[i] && id[i]==X. At most one entry matches any ID.
//  - req_ready_o (combinational from state): match exists && cnt<MaxTxnsPerId, OR no match and
//    a free entry exists. Independent of rsp_valid_i same cycle (no bypass).
//  - Accept = req_valid_i && req_ready_o. Hit: cnt+1. Miss: allocate lowest-index free entry,
//    id<=req_id_i, free<=0, cnt<=1. Updates visible next cycle (1-cycle latency).
//  - Retire: rsp_valid_i with matching entry -> cnt-1; cnt reaching 0 sets free<=1.
//    No match -> no state change, rsp_err_o=1 next cycle for one cycle.
//  - Simultaneous accept+retire, same entry: cnt unchanged, entry stays allocated.
//  - Simultaneous retire freeing entry k and miss-allocate: entry k is NOT reused that cycle;
//    allocation picks another free entry or req_ready_o=0 if none.
//  - Counters saturate-free by construction: cnt never exceeds MaxTxnsPerId nor goes below 0.
//  - full_o / empty_o derived from registered free vector (no combinational input path).
// CONFIGURATION
//  ID_TRACKER_TIMEOUT_EN defined: per-entry idle counter ($clog2(TimeoutCycles+1) bits),
//   cleared on alloc/accept/retire to that entry, increments each cycle while allocated,
//   saturates at TimeoutCycles. On reaching TimeoutCycles: timeout_o=1 for one cycle,
//   timeout_id_o=entry id; lowest index wins if several coincide, others fire next cycle(s).
//   Entry state is not modified by a timeout.
//  Not defined: no idle counters; timeout_o and timeout_id_o tied to 0.
// TESTING
//  1 Reset -> empty_o=1, full_o=0, req_ready_o=1; req id=3 -> entry0 id=3 cnt=1, empty_o=0.
//  2 req id=3 x8 (MaxTxnsPerId=8) -> req_ready_o=0 for id 3; req id=5 still accepted.
//  3 Fill ids 1,2,3,4 -> full_o=1; req id=7 -> ready=0; retire id 2 (cnt 1) -> id 7 next cycle
//    allocates entry1, not in retire cycle.
//  4 id 6 cnt=1: same-cycle req+rsp id 6 -> cnt stays 1, entry stays allocated.
//  5 rsp id=9 with no entry -> rsp_err_o=1 exactly one cycle later, table unchanged.
//  6 TIMEOUT_EN, TimeoutCycles=16: alloc id 2, idle 16 cycles -> timeout_o pulse,
//    timeout_id_o=2; reset asserted mid-count -> all outputs return to reset values.

Source files
------------

// File: rtl/id_tracker_table.sv
// rtl/id_tracker_table.sv - per-ID outstanding-transaction table with optional idle timeout
// Optional feature macro: ID_TRACKER_TIMEOUT_EN (per-entry idle counters and timeout pulse).
module id_tracker_table #(
    parameter int NumEntries    = 4,
    parameter int IdWidth       = 4,
    parameter int MaxTxnsPerId  = 8,
    parameter int TimeoutCycles = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    input  logic [IdWidth-1:0] req_id_i,
    output logic               req_ready_o,
    input  logic               rsp_valid_i,
    input  logic [IdWidth-1:0] rsp_id_i,
    output logic               rsp_err_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               timeout_o,
    output logic [IdWidth-1:0] timeout_id_o
);

    localparam int CntWidth = $clog2(MaxTxnsPerId + 1);
    localparam int IdxWidth = (NumEntries > 1) ? $clog2(NumEntries) : 1;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxnsPerId);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    logic [NumEntries-1:0][IdWidth-1:0]  id_q, id_d;
    logic [NumEntries-1:0][CntWidth-1:0] cnt_q, cnt_d;
    logic [NumEntries-1:0]               free_q, free_d;
    logic                                rsp_err_q, rsp_err_d;

    logic [NumEntries-1:0] req_hit_vec, rsp_hit_vec, touch;
    logic                  req_hit, rsp_hit, accept, retire;
    logic [IdxWidth-1:0]   req_idx, rsp_idx, alloc_idx;

    always_comb begin
        req_hit_vec = '0;
        rsp_hit_vec = '0;
        req_idx     = '0;
        rsp_idx     = '0;
        alloc_idx   = '0;
        for (int i = 0; i < NumEntries; i++) begin
            req_hit_vec[i] = !free_q[i] && (id_q[i] == req_id_i);
            rsp_hit_vec[i] = !free_q[i] && (id_q[i] == rsp_id_i);
            if (req_hit_vec[i]) req_idx = IdxWidth'(i);
            if (rsp_hit_vec[i]) rsp_idx = IdxWidth'(i);
        end
        // Descending scan so the lowest-index free entry wins.
        for (int i = NumEntries - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_idx = IdxWidth'(i);
        end
        req_hit = |req_hit_vec;
        rsp_hit = |rsp_hit_vec;
        if (req_hit) req_ready_o = (cnt_q[req_idx] < CntMax);
        else         req_ready_o = |free_q;
        accept = req_valid_i && req_ready_o;
        retire = rsp_valid_i && rsp_hit;
    end

    always_comb begin
        id_d      = id_q;
        cnt_d     = cnt_q;
        free_d    = free_q;
        touch     = '0;
        rsp_err_d = rsp_valid_i && !rsp_hit;
        for (int i = 0; i < NumEntries; i++) begin
            logic inc, alloc, dec;
            inc   = accept && req_hit && (req_idx == IdxWidth'(i));
            alloc = accept && !req_hit && (alloc_idx == IdxWidth'(i));
            dec   = retire && (rsp_idx == IdxWidth'(i));
            touch[i] = inc || alloc || dec;
            // A freshly freed entry is still marked allocated in free_q, so it cannot be chosen here.
            if (alloc) begin
                id_d[i]   = req_id_i;
                free_d[i] = 1'b0;
                cnt_d[i]  = CntOne;
            end else if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CntOne;
                if (cnt_q[i] == CntOne) free_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q      <= '0;
            cnt_q     <= '0;
            free_q    <= '1;
            rsp_err_q <= 1'b0;
        end else begin
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            free_q    <= free_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err_o = rsp_err_q;
    assign full_o    = ~|free_q;
    assign empty_o   = &free_q;

`ifdef ID_TRACKER_TIMEOUT_EN
    localparam int TmrWidth = $clog2(TimeoutCycles + 1);
    localparam logic [TmrWidth-1:0] TmrMax = TmrWidth'(TimeoutCycles);
    localparam logic [TmrWidth-1:0] TmrOne = TmrWidth'(1);

    logic [NumEntries-1:0][TmrWidth-1:0] idle_q, idle_d;
    logic [NumEntries-1:0]               pend_q, pend_d, pend_all;
    logic                                timeout_q, timeout_d;
    logic [IdWidth-1:0]                  timeout_id_q, timeout_id_d;

    always_comb begin
        idle_d       = idle_q;
        pend_all     = pend_q;
        timeout_d    = 1'b0;
        timeout_id_d = '0;
        for (int i = 0; i < NumEntries; i++) begin
            if (touch[i] || free_q[i]) begin
                idle_d[i] = '0;
            end else if (idle_q[i] != TmrMax) begin
                idle_d[i] = idle_q[i] + TmrOne;
                if (idle_d[i] == TmrMax) pend_all[i] = 1'b1;
            end
        end
        pend_all = pend_all & ~free_d;
        pend_d   = pend_all;
        // Report one entry per cycle; losers stay pending and fire on later cycles.
        for (int i = NumEntries - 1; i >= 0; i--) begin
            if (pend_all[i]) begin
                timeout_d    = 1'b1;
                timeout_id_d = id_q[i];
                pend_d       = pend_all & ~(NumEntries'(1) << i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_q       <= '0;
            pend_q       <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            idle_q       <= idle_d;
            pend_q       <= pend_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
        end
    end

    assign timeout_o    = timeout_q;
    assign timeout_id_o = timeout_id_q;
`else
    assign timeout_o    = 1'b0;
    assign timeout_id_o = '0;
`endif

endmodule

// File: tb/tb_id_tracker_table.sv
// tb/tb_id_tracker_table.sv - scoreboard bench for id_tracker_table (directed vectors)
module tb_id_tracker_table;

`ifdef ID_TRACKER_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, rsp_valid;
    logic [3:0] req_id, rsp_id;
    logic       req_ready, rsp_err, full, empty, timeout;
    logic [3:0] timeout_id;

    int checks   = 0;
    int failures = 0;
    int tagc     = 0;

    always #5 clk = ~clk;

    id_tracker_table #(
        .NumEntries(4), .IdWidth(4), .MaxTxnsPerId(8), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_id_i(req_id), .req_ready_o(req_ready),
        .rsp_valid_i(rsp_valid), .rsp_id_i(rsp_id), .rsp_err_o(rsp_err),
        .full_o(full), .empty_o(empty),
        .timeout_o(timeout), .timeout_id_o(timeout_id)
    );

    typedef struct {
        int         tag;
        logic       rdy, full, empty, err;
        bit         cto;
        logic       to;
        bit         cent;
        int         ent;
        logic [3:0] eid, ecnt;
        logic       efree;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input int tag, input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL step%0d %s got=%0h exp=%0h", tag, name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.tag, "req_ready", {3'b0, req_ready}, {3'b0, e.rdy});
            chk(e.tag, "full",      {3'b0, full},      {3'b0, e.full});
            chk(e.tag, "empty",     {3'b0, empty},     {3'b0, e.empty});
            chk(e.tag, "rsp_err",   {3'b0, rsp_err},   {3'b0, e.err});
            if (e.cto) begin
                chk(e.tag, "timeout", {3'b0, timeout}, {3'b0, e.to});
                if (e.to) chk(e.tag, "timeout_id", timeout_id, 4'd2);
                else      chk(e.tag, "timeout_id_idle", timeout_id, 4'd0);
            end
            if (e.cent) begin
                chk(e.tag, "ent_free", {3'b0, dut.free_q[e.ent]}, {3'b0, e.efree});
                chk(e.tag, "ent_cnt",  dut.cnt_q[e.ent], e.ecnt);
                if (!e.efree) chk(e.tag, "ent_id", dut.id_q[e.ent], e.eid);
            end
        end
    end

    task automatic cyc(input logic rv, input logic [3:0] rid, input logic sv, input logic [3:0] sid,
                       input logic rdy, input logic f, input logic em, input logic er,
                       input bit cto, input logic to,
                       input bit cent, input int ent, input logic [3:0] eid, input logic [3:0] ecnt,
                       input logic efree);
        exp_t e;
        @(posedge clk); #1;
        req_valid = rv; req_id = rid; rsp_valid = sv; rsp_id = sid;
        e.tag = tagc++; e.rdy = rdy; e.full = f; e.empty = em; e.err = er;
        e.cto = cto; e.to = to; e.cent = cent; e.ent = ent;
        e.eid = eid; e.ecnt = ecnt; e.efree = efree;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rv, input logic [3:0] rid, input logic sv, input logic [3:0] sid,
                        input logic rdy, input logic f, input logic em, input logic er);
        cyc(rv, rid, sv, sid, rdy, f, em, er, 0, 1'b0, 0, 0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic stepe(input logic rdy, input logic f, input logic em, input logic er,
                         input int ent, input logic [3:0] eid, input logic [3:0] ecnt, input logic efree);
        cyc(1'b0, 4'd0, 1'b0, 4'd0, rdy, f, em, er, 0, 1'b0, 1, ent, eid, ecnt, efree);
    endtask

    task automatic stept(input logic rv, input logic [3:0] rid, input logic em, input logic to);
        cyc(rv, rid, 1'b0, 4'd0, 1'b1, 1'b0, em, 1'b0, 1, to, 0, 0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic reset_pulse();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            rst_n = 1'b0; req_valid = 1'b0; rsp_valid = 1'b0; req_id = '0; rsp_id = '0;
            exp_q.push_back('{tag: tagc++, rdy: 1'b1, full: 1'b0, empty: 1'b1, err: 1'b0,
                              cto: 1, to: 1'b0, cent: 0, ent: 0, eid: 4'd0, ecnt: 4'd0, efree: 1'b1});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_valid = 1'b0; req_id = '0; rsp_id = '0;
        reset_pulse();

        // First allocation
        step(0, 4'd0, 0, 4'd0, 1, 0, 1, 0);
        step(1, 4'd3, 0, 4'd0, 1, 0, 1, 0);
        stepe(1, 0, 0, 0, 0, 4'd3, 4'd1, 1'b0);

        // Saturate id 3 at 8 outstanding
        for (int k = 0; k < 7; k++) step(1, 4'd3, 0, 4'd0, 1, 0, 0, 0);
        step(1, 4'd3, 0, 4'd0, 0, 0, 0, 0);
        step(1, 4'd5, 0, 4'd0, 1, 0, 0, 0);
        stepe(1, 0, 0, 0, 0, 4'd3, 4'd8, 1'b0);
        stepe(1, 0, 0, 0, 1, 4'd5, 4'd1, 1'b0);
        for (int k = 0; k < 8; k++) step(0, 4'd0, 1, 4'd3, 1, 0, 0, 0);
        step(0, 4'd0, 1, 4'd5, 1, 0, 0, 0);
        stepe(1, 0, 1, 0, 0, 4'd0, 4'd0, 1'b1);

        // Fill, blocked request, retire frees entry 1 only on the following cycle
        step(1, 4'd1, 0, 4'd0, 1, 0, 1, 0);
        step(1, 4'd2, 0, 4'd0, 1, 0, 0, 0);
        step(1, 4'd3, 0, 4'd0, 1, 0, 0, 0);
        step(1, 4'd4, 0, 4'd0, 1, 0, 0, 0);
        step(1, 4'd7, 0, 4'd0, 0, 1, 0, 0);
        step(1, 4'd7, 1, 4'd2, 0, 1, 0, 0);
        step(1, 4'd7, 0, 4'd0, 1, 0, 0, 0);
        stepe(0, 1, 0, 0, 1, 4'd7, 4'd1, 1'b0);
        step(0, 4'd1, 0, 4'd0, 1, 1, 0, 0);

        // Same-cycle accept and retire on id 6
        step(0, 4'd0, 1, 4'd4, 0, 1, 0, 0);
        step(1, 4'd6, 0, 4'd0, 1, 0, 0, 0);
        step(1, 4'd6, 1, 4'd6, 1, 1, 0, 0);
        stepe(0, 1, 0, 0, 3, 4'd6, 4'd1, 1'b0);

        // Retire of unknown id 9
        step(0, 4'd0, 1, 4'd9, 0, 1, 0, 0);
        stepe(0, 1, 0, 1, 0, 4'd1, 4'd1, 1'b0);
        stepe(0, 1, 0, 0, 2, 4'd3, 4'd1, 1'b0);

        // Reset mid-operation
        reset_pulse();
        stept(0, 4'd0, 1, 1'b0);

        // Idle timeout on id 2: pulse 17 cycles after the allocating cycle
        stept(1, 4'd2, 1, 1'b0);
        for (int k = 1; k <= 16; k++) stept(0, 4'd0, 0, 1'b0);
        stept(0, 4'd0, 0, TO_EN);
        stept(0, 4'd0, 0, 1'b0);
        stept(0, 4'd0, 0, 1'b0);

        // Restart the idle count, then reset before it expires
        stept(1, 4'd2, 0, 1'b0);
        for (int k = 0; k < 5; k++) stept(0, 4'd0, 0, 1'b0);
        reset_pulse();
        for (int k = 0; k < 20; k++) stept(0, 4'd0, 1, 1'b0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
